// File: rtl/axil_cmd_master.sv
// AXI4-Lite master that queues read/write register commands in a small FIFO and replays them
// one at a time on the bus, returning one response per command with a per-phase timeout.
module axil_cmd_master #(
  parameter int unsigned                   C_M_AXI_ADDR_WIDTH         = 32,
  parameter logic [C_M_AXI_ADDR_WIDTH-1:0] C_M_TARGET_SLAVE_BASE_ADDR = '0,
  parameter int unsigned                   C_M_AXI_DATA_WIDTH         = 32,
  parameter int unsigned                   C_CMD_ADDR_WIDTH           = 4,
  parameter int unsigned                   C_CMD_DEPTH                = 4,
  parameter int unsigned                   C_TIMEOUT                  = 256
) (
  input  logic                              M_AXI_ACLK,
  input  logic                              M_AXI_ARESETN,
  // command side
  input  logic                              CMD_VALID,
  output logic                              CMD_READY,
  input  logic                              CMD_DIR,
  input  logic [C_CMD_ADDR_WIDTH-1:0]       CMD_ADDR,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     CMD_DATA,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   CMD_STRB,
  // response side
  output logic                              RSP_VALID,
  input  logic                              RSP_READY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     RSP_DATA,
  output logic [1:0]                        RSP_RESP,
  output logic                              RSP_DIR,
  output logic                              RSP_TIMEOUT,
  output logic                              BUSY,
  output logic                              ERROR,
  input  logic                              ERR_CLR,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [2:0]                        M_AXI_AWPROT,
  output logic                              M_AXI_AWVALID,
  input  logic                              M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                              M_AXI_WVALID,
  input  logic                              M_AXI_WREADY,
  input  logic [1:0]                        M_AXI_BRESP,
  input  logic                              M_AXI_BVALID,
  output logic                              M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [2:0]                        M_AXI_ARPROT,
  output logic                              M_AXI_ARVALID,
  input  logic                              M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                        M_AXI_RRESP,
  input  logic                              M_AXI_RVALID,
  output logic                              M_AXI_RREADY
);

  localparam int unsigned DW    = C_M_AXI_DATA_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned AW    = C_M_AXI_ADDR_WIDTH;
  localparam int unsigned CW    = C_CMD_ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(C_CMD_DEPTH);
  localparam int unsigned CNT_W = $clog2(C_CMD_DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(C_TIMEOUT);

  typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRd, StRdData, StRsp} state_e;

  state_e r_state, w_state_d;

  logic          r_fifo_dir  [C_CMD_DEPTH];
  logic [CW-1:0] r_fifo_addr [C_CMD_DEPTH];
  logic [DW-1:0] r_fifo_data [C_CMD_DEPTH];
  logic [SW-1:0] r_fifo_strb [C_CMD_DEPTH];

  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_aw_done, r_w_done;
  logic [AW-1:0]    r_awaddr, r_araddr;
  logic [DW-1:0]    r_wdata;
  logic [SW-1:0]    r_wstrb;
  logic [DW-1:0]    r_rsp_data;
  logic [1:0]       r_rsp_resp;
  logic             r_rsp_dir, r_rsp_to;
  logic             r_error;

  logic w_full, w_push, w_pop, w_aw_hs, w_w_hs, w_tmo_max, w_in_wait, w_to;
  logic w_b_take, w_r_take, w_err_set;

  assign w_full    = (r_count == CNT_W'(C_CMD_DEPTH));
  assign w_push    = CMD_VALID & CMD_READY;
  assign w_pop     = (r_state == StIdle) && (r_count != '0);
  assign w_aw_hs   = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_w_hs    = M_AXI_WVALID & M_AXI_WREADY;
  assign w_tmo_max = (r_tmo_cnt == TMO_W'(C_TIMEOUT - 1));
  assign w_in_wait = (r_state == StWr) || (r_state == StWrResp) ||
                     (r_state == StRd) || (r_state == StRdData);
  assign w_b_take  = (r_state == StWrResp) && M_AXI_BVALID;
  assign w_r_take  = (r_state == StRdData) && M_AXI_RVALID;
  assign w_err_set = w_to | (w_b_take & M_AXI_BRESP[1]) | (w_r_take & M_AXI_RRESP[1]);

  // State register
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) r_state <= StIdle;
    else                r_state <= w_state_d;
  end

  // Next-state logic; a completing handshake wins over a timeout on the same edge
  always_comb begin
    w_state_d = r_state;
    w_to      = 1'b0;
    unique case (r_state)
      StIdle: if (w_pop) w_state_d = r_fifo_dir[r_rptr] ? StWr : StRd;
      StWr: begin
        if ((r_aw_done | w_aw_hs) && (r_w_done | w_w_hs)) begin
          w_state_d = StWrResp;
        end else if (w_tmo_max) begin
          w_state_d = StRsp;
          w_to      = 1'b1;
        end
      end
      StWrResp: begin
        if (M_AXI_BVALID) begin
          w_state_d = StRsp;
        end else if (w_tmo_max) begin
          w_state_d = StRsp;
          w_to      = 1'b1;
        end
      end
      StRd: begin
        if (M_AXI_ARREADY) begin
          w_state_d = StRdData;
        end else if (w_tmo_max) begin
          w_state_d = StRsp;
          w_to      = 1'b1;
        end
      end
      StRdData: begin
        if (M_AXI_RVALID) begin
          w_state_d = StRsp;
        end else if (w_tmo_max) begin
          w_state_d = StRsp;
          w_to      = 1'b1;
        end
      end
      StRsp:   if (RSP_READY) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    CMD_READY     = M_AXI_ARESETN && !w_full;
    M_AXI_AWVALID = (r_state == StWr) && !r_aw_done;
    M_AXI_WVALID  = (r_state == StWr) && !r_w_done;
    M_AXI_BREADY  = (r_state == StWrResp);
    M_AXI_ARVALID = (r_state == StRd);
    M_AXI_RREADY  = (r_state == StRdData);
    RSP_VALID     = (r_state == StRsp);
    BUSY          = (r_count != '0) || (r_state != StIdle);
  end

  // FIFO storage needs no reset; only the pointers and count define its contents
  always_ff @(posedge M_AXI_ACLK) begin
    if (w_push) begin
      r_fifo_dir[r_wptr]  <= CMD_DIR;
      r_fifo_addr[r_wptr] <= CMD_ADDR;
      r_fifo_data[r_wptr] <= CMD_DATA;
      r_fifo_strb[r_wptr] <= CMD_STRB;
    end
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_tmo_cnt  <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_rsp_data <= '0;
      r_rsp_resp <= '0;
      r_rsp_dir  <= 1'b0;
      r_rsp_to   <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop) begin
        r_rptr    <= r_rptr + PTR_W'(1);
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_rsp_dir <= r_fifo_dir[r_rptr];
        if (r_fifo_dir[r_rptr]) begin
          r_awaddr <= C_M_TARGET_SLAVE_BASE_ADDR + AW'(r_fifo_addr[r_rptr]);
          r_wdata  <= r_fifo_data[r_rptr];
          r_wstrb  <= r_fifo_strb[r_rptr];
        end else begin
          r_araddr <= C_M_TARGET_SLAVE_BASE_ADDR + AW'(r_fifo_addr[r_rptr]);
        end
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (w_pop && !w_push) r_count <= r_count - CNT_W'(1);

      if (w_state_d != r_state) r_tmo_cnt <= '0;
      else if (w_in_wait)       r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);

      if (w_b_take) begin
        r_rsp_data <= '0;
        r_rsp_resp <= M_AXI_BRESP;
        r_rsp_to   <= 1'b0;
      end else if (w_r_take) begin
        r_rsp_data <= M_AXI_RDATA;
        r_rsp_resp <= M_AXI_RRESP;
        r_rsp_to   <= 1'b0;
      end else if (w_to) begin
        r_rsp_data <= '0;
        r_rsp_resp <= 2'b10;
        r_rsp_to   <= 1'b1;
      end

      // A new error outranks a simultaneous clear
      r_error <= w_err_set | (r_error & ~ERR_CLR);
    end
  end

  assign M_AXI_AWADDR = r_awaddr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = r_wstrb;
  assign M_AXI_ARADDR = r_araddr;
  assign M_AXI_ARPROT = 3'b001;
  assign RSP_DATA     = r_rsp_data;
  assign RSP_RESP     = r_rsp_resp;
  assign RSP_DIR      = r_rsp_dir;
  assign RSP_TIMEOUT  = r_rsp_to;
  assign ERROR        = r_error;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: a hand-driven AXI4-Lite slave with expected values
// written out per step; inputs change and outputs are sampled on the falling clock edge.
module tb_axil_cmd_master;

  localparam logic [31:0] Base = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [3:0]  cmd_addr, cmd_strb;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready, rsp_dir, rsp_timeout, busy, error, err_clr;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axil_cmd_master #(
    .C_M_AXI_ADDR_WIDTH        (32),
    .C_M_TARGET_SLAVE_BASE_ADDR(Base),
    .C_M_AXI_DATA_WIDTH        (32),
    .C_CMD_ADDR_WIDTH          (4),
    .C_CMD_DEPTH               (4),
    .C_TIMEOUT                 (16)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_DIR      (cmd_dir),
    .CMD_ADDR     (cmd_addr),
    .CMD_DATA     (cmd_data),
    .CMD_STRB     (cmd_strb),
    .RSP_VALID    (rsp_valid),
    .RSP_READY    (rsp_ready),
    .RSP_DATA     (rsp_data),
    .RSP_RESP     (rsp_resp),
    .RSP_DIR      (rsp_dir),
    .RSP_TIMEOUT  (rsp_timeout),
    .BUSY         (busy),
    .ERROR        (error),
    .ERR_CLR      (err_clr),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWPROT (awprot),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARPROT (arprot),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge after the command was accepted.
  task automatic push(input logic d, input logic [3:0] a, input logic [31:0] dat,
                      input logic [3:0] s);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_addr  = a;
    cmd_data  = dat;
    cmd_strb  = s;
    for (int k = 0; k < 60 && !ok; k++) begin
      ok = cmd_ready;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 64'(ok), 64'd1);
  endtask

  task automatic serve_wr(input string tag, input logic [31:0] ea, input logic [31:0] ed,
                          input logic [3:0] es, input int aw_lat, input int w_lat,
                          input logic [1:0] br, input logic clr);
    int n_aw = 0;
    int n_w  = 0;
    int m    = (aw_lat > w_lat) ? aw_lat : w_lat;
    for (int k = 0; k < 30 && !awvalid; k++) @(negedge clk);
    chk({tag, "_awvalid"}, 64'(awvalid), 64'd1);
    chk({tag, "_wvalid"}, 64'(wvalid), 64'd1);
    chk({tag, "_awaddr"}, 64'(awaddr), 64'(ea));
    chk({tag, "_wdata"}, 64'(wdata), 64'(ed));
    chk({tag, "_wstrb"}, 64'(wstrb), 64'(es));
    chk({tag, "_awprot"}, 64'(awprot), 64'd0);
    for (int k = 0; k <= m; k++) begin
      awready = (k == aw_lat);
      wready  = (k == w_lat);
      if (awvalid && awready) n_aw++;
      if (wvalid && wready) n_w++;
      @(negedge clk);
    end
    awready = 1'b0;
    wready  = 1'b0;
    chk({tag, "_aw_beats"}, 64'(n_aw), 64'd1);
    chk({tag, "_w_beats"}, 64'(n_w), 64'd1);
    chk({tag, "_valids_low"}, 64'({awvalid, wvalid}), 64'd0);
    chk({tag, "_bready"}, 64'(bready), 64'd1);
    bvalid  = 1'b1;
    bresp   = br;
    err_clr = clr;
    @(negedge clk);
    bvalid  = 1'b0;
    bresp   = 2'b00;
    err_clr = 1'b0;
  endtask

  task automatic serve_rd(input string tag, input logic [31:0] ea, input logic [31:0] d,
                          input logic [1:0] rr);
    for (int k = 0; k < 30 && !arvalid; k++) @(negedge clk);
    chk({tag, "_arvalid"}, 64'(arvalid), 64'd1);
    chk({tag, "_araddr"}, 64'(araddr), 64'(ea));
    chk({tag, "_arprot"}, 64'(arprot), 64'd1);
    arready = 1'b1;
    @(negedge clk);
    arready = 1'b0;
    chk({tag, "_arvalid_drop"}, 64'(arvalid), 64'd0);
    chk({tag, "_rready"}, 64'(rready), 64'd1);
    rvalid = 1'b1;
    rdata  = d;
    rresp  = rr;
    @(negedge clk);
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
  endtask

  // Holds RSP_READY low for one cycle first so field stability is observed.
  task automatic take_rsp(input string tag, input logic [31:0] d, input logic [1:0] r,
                          input logic dir, input logic to);
    for (int k = 0; k < 40 && !rsp_valid; k++) @(negedge clk);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(d));
    chk({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(r));
    chk({tag, "_rsp_dir"}, 64'(rsp_dir), 64'(dir));
    chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(to));
    @(negedge clk);
    chk({tag, "_rsp_hold"}, 64'({rsp_valid, rsp_data, rsp_resp}), 64'({1'b1, d, r}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_done"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_data = '0;
    cmd_strb = '0; rsp_ready = 1'b0; err_clr = 1'b0; awready = 1'b0; wready = 1'b0;
    bvalid = 1'b0; bresp = '0; arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_axi_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_awaddr", 64'(awaddr), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", 64'(cmd_ready), 64'd1);

    // Basic write, checking pop latency
    push(1'b1, 4'h4, 32'h0000_00A5, 4'h1);
    chk("lat_awvalid_idle", 64'(awvalid), 64'd0);
    chk("lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("lat_awvalid_up", 64'(awvalid), 64'd1);
    serve_wr("wr1", Base + 32'h4, 32'h0000_00A5, 4'h1, 0, 0, 2'b00, 1'b0);
    take_rsp("wr1", 32'h0, 2'b00, 1'b1, 1'b0);
    chk("wr1_error", 64'(error), 64'd0);
    chk("wr1_idle", 64'(busy), 64'd0);

    // Basic read
    push(1'b0, 4'h8, 32'h0, 4'h0);
    serve_rd("rd1", Base + 32'h8, 32'hDEAD_BEEF, 2'b00);
    take_rsp("rd1", 32'hDEAD_BEEF, 2'b00, 1'b0, 1'b0);

    // AW and W accepted on different edges
    push(1'b1, 4'hC, 32'h1111_2222, 4'hF);
    serve_wr("aw_first", Base + 32'hC, 32'h1111_2222, 4'hF, 0, 3, 2'b00, 1'b0);
    take_rsp("aw_first", 32'h0, 2'b00, 1'b1, 1'b0);
    push(1'b1, 4'h0, 32'h3333_4444, 4'h3);
    serve_wr("w_first", Base, 32'h3333_4444, 4'h3, 3, 0, 2'b00, 1'b0);
    take_rsp("w_first", 32'h0, 2'b00, 1'b1, 1'b0);

    // SLVERR with ERR_CLR on the same edge: error must stick
    push(1'b1, 4'h2, 32'h55, 4'h1);
    serve_wr("slverr", Base + 32'h2, 32'h55, 4'h1, 0, 0, 2'b10, 1'b1);
    chk("slverr_err_beats_clr", 64'(error), 64'd1);
    take_rsp("slverr", 32'h0, 2'b10, 1'b1, 1'b0);
    chk("slverr_sticky", 64'(error), 64'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 64'(error), 64'd0);

    // Fill the FIFO while the first write stalls; first is popped at once, four queue up
    for (int i = 0; i < 5; i++) push(1'b1, 4'(i), 32'h100 + 32'(i), 4'hF);
    chk("fifo_full", 64'(cmd_ready), 64'd0);
    chk("fifo_busy", 64'(busy), 64'd1);
    cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_addr = 4'h5; cmd_data = 32'h105; cmd_strb = 4'hF;
    serve_wr("q0", Base, 32'h100, 4'hF, 0, 0, 2'b00, 1'b0);
    take_rsp("q0", 32'h0, 2'b00, 1'b1, 1'b0);
    chk("full_pop_edge_refuse", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("after_pop_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    chk("refill_full", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b0;
    for (int i = 1; i < 6; i++) begin
      serve_wr("q", Base + 32'(i), 32'h100 + 32'(i), 4'hF, 0, 0, 2'b00, 1'b0);
      take_rsp("q", 32'h0, 2'b00, 1'b1, 1'b0);
    end
    chk("q_drained", 64'(busy), 64'd0);

    // Read timeout: ARREADY never comes
    push(1'b0, 4'h6, 32'h0, 4'h0);
    for (int k = 0; k < 10 && !arvalid; k++) @(negedge clk);
    chk("tmo_arvalid", 64'(arvalid), 64'd1);
    n = 0;
    while (arvalid && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", 64'(n), 64'd16);
    chk("tmo_axi_quiet", 64'({arvalid, rready}), 64'd0);
    take_rsp("tmo", 32'h0, 2'b10, 1'b0, 1'b1);
    chk("tmo_error", 64'(error), 64'd1);

    // Reset in WR_RESP with RSP_READY low, error still set from the timeout
    push(1'b1, 4'h7, 32'h77, 4'h1);
    for (int k = 0; k < 10 && !awvalid; k++) @(negedge clk);
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    awready = 1'b0;
    wready  = 1'b0;
    chk("mid_bready", 64'(bready), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_axi", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("mid_rst_error", 64'(error), 64'd0);
    chk("mid_rst_regs", 64'({awaddr, wdata}), 64'd0);
    chk("mid_rst_rsp_fields", 64'({rsp_data, rsp_resp, rsp_dir, rsp_timeout}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rel_cmd_ready", 64'(cmd_ready), 64'd1);
    push(1'b1, 4'h9, 32'h99, 4'h1);
    serve_wr("post_rst", Base + 32'h9, 32'h99, 4'h1, 0, 0, 2'b00, 1'b0);
    take_rsp("post_rst", 32'h0, 2'b00, 1'b1, 1'b0);
    chk("post_rst_error", 64'(error), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
